// File: rtl/sparse_index_decoder.sv
// sparse_index_decoder: rebuilds absolute linear indices from a compressed
// (value, zero-run) activation stream and issues non-zeros as one-cycle
// dividend pulses to the index divider. Handles consumer stall, tile framing
// and index-range checking.
// Optional feature macro: SPARSE_IDX_NZCNT_EN adds nz_count (non-zeros issued
// in the current tile).
module sparse_index_decoder #(
  parameter int unsigned ROWS   = 16,
  parameter int unsigned COLS   = 16,
  parameter int unsigned N      = $clog2(ROWS*COLS) + 1,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ZRUN_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_value,
  input  logic [ZRUN_W-1:0] in_zrun,
  input  logic              in_last,
  input  logic              out_stall,
  output logic              data_rdy,
  output logic [N-1:0]      dividend,
  output logic [DATA_W-1:0] out_value,
  output logic              out_last,
  output logic              tile_done,
  output logic              err_overflow
`ifdef SPARSE_IDX_NZCNT_EN
  ,
  output logic [N:0]        nz_count
`endif
);

  localparam int unsigned TILE    = ROWS * COLS;
  localparam logic [N:0]  IDX_MAX = (N+1)'(TILE - 1);

  typedef enum logic {ST_RUN, ST_ERR} state_t;

  state_t              state_q, state_d;
  logic [N-1:0]        base_q, base_d;
  logic                hold_valid_q, hold_valid_d;
  logic [N-1:0]        dividend_q, dividend_d;
  logic [DATA_W-1:0]   value_q, value_d;
  logic                last_q, last_d;
  logic                done_pend_q, done_pend_d;
  logic                err_q, err_d;

  logic                issue;
  logic                accept;
  logic [N:0]          idx;
  logic                overflow;

  // Issue, acceptance and index arithmetic; reset suppresses any pending issue
  assign issue    = ~rst & hold_valid_q & ~out_stall;
  assign in_ready = ~rst & ((state_q == ST_ERR) | ~hold_valid_q | ~out_stall);
  assign accept   = in_valid & in_ready;
  assign idx      = (N+1)'(base_q) + (N+1)'(in_zrun);
  assign overflow = (idx > IDX_MAX);

  assign data_rdy     = issue;
  assign dividend     = dividend_q;
  assign out_value    = value_q;
  assign out_last     = last_q;
  assign err_overflow = err_q;
  assign tile_done    = ~rst & ((issue & last_q) | done_pend_q);

  // Next-state: framing FSM, running base and holding register
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    hold_valid_d = hold_valid_q & ~issue;
    dividend_d   = dividend_q;
    value_d      = value_q;
    last_d       = last_q;
    done_pend_d  = 1'b0;
    err_d        = err_q;

    case (state_q)
      ST_RUN: begin
        if (accept) begin
          if (overflow) begin
            // Offending entry is dropped; framing resyncs at in_last
            err_d = 1'b1;
            if (in_last) begin
              base_d      = '0;
              done_pend_d = 1'b1;
            end else begin
              state_d = ST_ERR;
            end
          end else begin
            base_d = in_last ? '0 : N'(idx + (N+1)'(1));
            if (in_value != '0) begin
              hold_valid_d = 1'b1;
              dividend_d   = idx[N-1:0];
              value_d      = in_value;
              last_d       = in_last;
            end else if (in_last) begin
              done_pend_d = 1'b1;
            end
          end
        end
      end
      ST_ERR: begin
        if (accept && in_last) begin
          base_d      = '0;
          done_pend_d = 1'b1;
          state_d     = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      base_q       <= '0;
      hold_valid_q <= 1'b0;
      dividend_q   <= '0;
      value_q      <= '0;
      last_q       <= 1'b0;
      done_pend_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      hold_valid_q <= hold_valid_d;
      dividend_q   <= dividend_d;
      value_q      <= value_d;
      last_q       <= last_d;
      done_pend_q  <= done_pend_d;
      err_q        <= err_d;
    end
  end

`ifdef SPARSE_IDX_NZCNT_EN
  logic [N:0] cnt_q, cnt_d;

  // Per-tile issue count; reported value includes the current cycle's issue
  always_comb begin
    nz_count = cnt_q + (N+1)'(issue);
    cnt_d    = tile_done ? '0 : nz_count;
  end

  // Count register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`endif

endmodule

// File: tb/tb_sparse_index_decoder.sv
// Directed self-checking bench for sparse_index_decoder.
module tb_sparse_index_decoder;

  localparam int unsigned N      = 9;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned ZRUN_W = 4;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_value;
  logic [ZRUN_W-1:0] in_zrun;
  logic              in_last;
  logic              out_stall;
  logic              data_rdy;
  logic [N-1:0]      dividend;
  logic [DATA_W-1:0] out_value;
  logic              out_last;
  logic              tile_done;
  logic              err_overflow;
`ifdef SPARSE_IDX_NZCNT_EN
  logic [N:0]        nz_count;
`endif

  int n_cmp;
  int n_fail;

  sparse_index_decoder dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_value     (in_value),
    .in_zrun      (in_zrun),
    .in_last      (in_last),
    .out_stall    (out_stall),
    .data_rdy     (data_rdy),
    .dividend     (dividend),
    .out_value    (out_value),
    .out_last     (out_last),
    .tile_done    (tile_done),
    .err_overflow (err_overflow)
`ifdef SPARSE_IDX_NZCNT_EN
    ,
    .nz_count     (nz_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int v, input int z, input bit l);
    in_valid = 1'b1;
    in_value = DATA_W'(v);
    in_zrun  = ZRUN_W'(z);
    in_last  = l;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_value = '0;
    in_zrun  = '0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; out_stall = 1'b0; idle();
    step(); step();
    n_cmp++;
    if ({in_ready, data_rdy, dividend, out_value, out_last, tile_done, err_overflow} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs rdy=%b drdy=%b div=%0d val=%0d last=%b done=%b err=%b want all 0",
               in_ready, data_rdy, dividend, out_value, out_last, tile_done, err_overflow);
    end
    rst = 1'b0;
    step();
    n_cmp++;
    if (in_ready !== 1'b1 || data_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release in_ready=%b data_rdy=%b want 1/0", in_ready, data_rdy);
    end
  endtask

  task automatic test_back_to_back();
    drv(5, 0, 0); step();
    n_cmp++;
    if (data_rdy !== 1'b1 || dividend !== 9'd0 || out_value !== 16'd5 || out_last !== 1'b0 || tile_done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_first drdy=%b div=%0d val=%0d last=%b done=%b want 1/0/5/0/0",
               data_rdy, dividend, out_value, out_last, tile_done);
    end
    drv(7, 2, 0); step();
    n_cmp++;
    if (data_rdy !== 1'b1 || dividend !== 9'd3 || out_value !== 16'd7) begin
      n_fail++;
      $display("FAIL b2b_second drdy=%b div=%0d val=%0d want 1/3/7", data_rdy, dividend, out_value);
    end
    drv(9, 0, 1); step();
    n_cmp++;
    if (data_rdy !== 1'b1 || dividend !== 9'd4 || out_value !== 16'd9 || out_last !== 1'b1 || tile_done !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_third drdy=%b div=%0d val=%0d last=%b done=%b want 1/4/9/1/1",
               data_rdy, dividend, out_value, out_last, tile_done);
    end
`ifdef SPARSE_IDX_NZCNT_EN
    n_cmp++;
    if (nz_count !== 10'd3) begin
      n_fail++;
      $display("FAIL nzcnt_at_done nz_count=%0d want 3", nz_count);
    end
`endif
    idle(); step();
    n_cmp++;
    if (data_rdy !== 1'b0 || tile_done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_gap drdy=%b done=%b want 0/0", data_rdy, tile_done);
    end
`ifdef SPARSE_IDX_NZCNT_EN
    n_cmp++;
    if (nz_count !== 10'd0) begin
      n_fail++;
      $display("FAIL nzcnt_cleared nz_count=%0d want 0", nz_count);
    end
`endif
    drv(1, 1, 1); step();
    n_cmp++;
    if (data_rdy !== 1'b1 || dividend !== 9'd1 || out_value !== 16'd1 || tile_done !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_next_tile drdy=%b div=%0d val=%0d done=%b want 1/1/1/1",
               data_rdy, dividend, out_value, tile_done);
    end
    idle(); step();
  endtask

  task automatic test_placeholder();
    drv(0, 15, 0); step();
    n_cmp++;
    if (data_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL ph_no_issue data_rdy=%b want 0", data_rdy);
    end
    drv(3, 1, 1); step();
    n_cmp++;
    if (data_rdy !== 1'b1 || dividend !== 9'd17 || out_value !== 16'd3 || tile_done !== 1'b1) begin
      n_fail++;
      $display("FAIL ph_issue drdy=%b div=%0d val=%0d done=%b want 1/17/3/1",
               data_rdy, dividend, out_value, tile_done);
    end
    idle(); step();
    n_cmp++;
    if (data_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL ph_single data_rdy=%b want 0", data_rdy);
    end
    drv(0, 3, 1); step();
    n_cmp++;
    if (data_rdy !== 1'b0 || tile_done !== 1'b1) begin
      n_fail++;
      $display("FAIL ph_last drdy=%b done=%b want 0/1", data_rdy, tile_done);
    end
    idle(); step();
    n_cmp++;
    if (tile_done !== 1'b0) begin
      n_fail++;
      $display("FAIL ph_last_pulse tile_done=%b want 0", tile_done);
    end
  endtask

  task automatic test_stall();
    out_stall = 1'b1;
    drv(4, 0, 0); step();
    idle();
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (data_rdy !== 1'b0 || dividend !== 9'd0 || out_value !== 16'd4 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold cyc=%0d drdy=%b div=%0d val=%0d rdy=%b want 0/0/4/0",
                 i, data_rdy, dividend, out_value, in_ready);
      end
      if (i < 2) step();
    end
    out_stall = 1'b0;
    #1;
    n_cmp++;
    if (data_rdy !== 1'b1 || dividend !== 9'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release drdy=%b div=%0d rdy=%b want 1/0/1", data_rdy, dividend, in_ready);
    end
    step();
    n_cmp++;
    if (data_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_no_dup data_rdy=%b want 0", data_rdy);
    end
    drv(0, 0, 1); step();
    idle(); step();
  endtask

  task automatic test_boundary();
    for (int i = 0; i < 15; i++) begin drv(0, 15, 0); step(); end
    drv(0, 14, 0); step();
    drv(7, 0, 1); step();
    n_cmp++;
    if (data_rdy !== 1'b1 || dividend !== 9'd255 || err_overflow !== 1'b0 || tile_done !== 1'b1) begin
      n_fail++;
      $display("FAIL max_index drdy=%b div=%0d err=%b done=%b want 1/255/0/1",
               data_rdy, dividend, err_overflow, tile_done);
    end
    idle(); step();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 15; i++) begin drv(0, 15, 0); step(); end
    drv(0, 9, 0); step();
    drv(6, 10, 0); step();
    n_cmp++;
    if (data_rdy !== 1'b0 || err_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_drop drdy=%b err=%b want 0/1", data_rdy, err_overflow);
    end
    drv(8, 0, 0); step();
    n_cmp++;
    if (data_rdy !== 1'b0 || in_ready !== 1'b1 || tile_done !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_discard drdy=%b rdy=%b done=%b want 0/1/0", data_rdy, in_ready, tile_done);
    end
    drv(8, 0, 1); step();
    n_cmp++;
    if (data_rdy !== 1'b0 || tile_done !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_tile_done drdy=%b done=%b want 0/1", data_rdy, tile_done);
    end
    drv(2, 0, 1); step();
    n_cmp++;
    if (data_rdy !== 1'b1 || dividend !== 9'd0 || out_value !== 16'd2 || err_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_recover drdy=%b div=%0d val=%0d err=%b want 1/0/2/1",
               data_rdy, dividend, out_value, err_overflow);
    end
    idle(); step();
  endtask

  task automatic test_reset_mid_tile();
    drv(0, 15, 0); step();
    drv(0, 15, 0); step();
    drv(0, 7, 0); step();
    out_stall = 1'b1;
    drv(5, 0, 0); step();
    idle();
    n_cmp++;
    if (data_rdy !== 1'b0 || dividend !== 9'd40) begin
      n_fail++;
      $display("FAIL rmt_pending drdy=%b div=%0d want 0/40", data_rdy, dividend);
    end
    rst = 1'b1; out_stall = 1'b0;
    #1;
    n_cmp++;
    if (data_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL rmt_no_issue data_rdy=%b want 0", data_rdy);
    end
    step();
    n_cmp++;
    if ({in_ready, data_rdy, dividend, out_value, out_last, tile_done, err_overflow} !== '0) begin
      n_fail++;
      $display("FAIL rmt_outputs rdy=%b drdy=%b div=%0d val=%0d last=%b done=%b err=%b want all 0",
               in_ready, data_rdy, dividend, out_value, out_last, tile_done, err_overflow);
    end
    rst = 1'b0;
    drv(2, 0, 1); step();
    n_cmp++;
    if (data_rdy !== 1'b1 || dividend !== 9'd0 || out_value !== 16'd2 || tile_done !== 1'b1) begin
      n_fail++;
      $display("FAIL rmt_restart drdy=%b div=%0d val=%0d done=%b want 1/0/2/1",
               data_rdy, dividend, out_value, tile_done);
    end
    idle(); step();
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b1;
    out_stall = 1'b0;
    idle();
    test_reset();
    test_back_to_back();
    test_placeholder();
    test_stall();
    test_boundary();
    test_overflow();
    test_reset_mid_tile();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
